// File: rtl/fifo_to_video_ctrl.sv
// fifo_to_video_ctrl
//   Read-side video unpacker. Requests one AXI read burst per video line,
//   pops AXI4_DATA_WIDTH-bit words from the DDR read FIFO (1-cycle read
//   latency, show-ahead off) and emits PPW = AXI4_DATA_WIDTH/32 pixels per
//   word in step with the timing generator. Timing signals are delayed two
//   cycles so they line up with the pixel data.
//
// Ports
//   video_clk, video_rst_n      clock, async active-low reset
//   video_vs_in/hs_in/de_in     timing generator inputs (vs high = frame active)
//   fifo_data_in, fifo_empty    read FIFO data (valid 1 cycle after pop), empty flag
//   fifo_rd_en                  read FIFO pop (combinational)
//   video_vs/hs/de_out          timing delayed 2 cycles
//   video_data_out              24-bit RGB pixel
//   AXI_FULL_BURST_VALID/READY  line read burst request handshake
//   underflow                   sticky, set when a word was needed but the FIFO was empty
module fifo_to_video_ctrl #(
  parameter int AXI4_DATA_WIDTH = 128,
  parameter int H_ACTIVE        = 1920,
  parameter int V_ACTIVE        = 1080
) (
  input  logic                       video_clk,
  input  logic                       video_rst_n,
  input  logic                       video_vs_in,
  input  logic                       video_hs_in,
  input  logic                       video_de_in,
  input  logic [AXI4_DATA_WIDTH-1:0] fifo_data_in,
  input  logic                       fifo_empty,
  output logic                       fifo_rd_en,
  output logic                       video_vs_out,
  output logic                       video_hs_out,
  output logic                       video_de_out,
  output logic [23:0]                video_data_out,
  output logic                       AXI_FULL_BURST_VALID,
  input  logic                       AXI_FULL_BURST_READY,
  output logic                       underflow
);

  localparam int W   = AXI4_DATA_WIDTH;
  localparam int PPW = W / 32;
  localparam int PCW = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int LRW = $clog2(V_ACTIVE + 1);

  if (((W % 32) != 0) || ((H_ACTIVE % PPW) != 0)) begin : g_bad_cfg
    $error("fifo_to_video_ctrl: data width or H_ACTIVE not a multiple of the pixel word");
  end

  logic [PCW-1:0] pix_cnt;
  logic           sel0;
  logic           rd_ok;
  logic           rd_ok_d1;
  logic           sel0_d1;
  logic           de_d1;
  logic           vs_d1;
  logic           hs_d1;
  logic [W-1:0]   shreg;
  logic [LRW-1:0] line_req;
  logic [1:0]     pending;
  logic [1:0]     pending_nxt;
  logic           vs_rise;
  logic           hs_fall;
  logic           req_event;
  logic           req_accept;
  logic           underflow_set;
  logic           unused_alpha;

  assign sel0          = video_de_in && (pix_cnt == '0);
  assign rd_ok         = sel0 && !fifo_empty;
  assign fifo_rd_en    = rd_ok;

  // vs_d1/hs_d1 double as the first stage of the timing delay pipe.
  assign vs_rise       = video_vs_in && !vs_d1;
  assign hs_fall       = !video_hs_in && hs_d1;
  assign underflow_set = de_d1 && sel0_d1 && !rd_ok_d1;

  assign req_accept    = AXI_FULL_BURST_VALID && AXI_FULL_BURST_READY;
  assign req_event     = vs_rise ||
                         (video_vs_in && hs_fall && (line_req < LRW'(V_ACTIVE)));

  // The 0xff filler byte of every pixel slot is discarded.
  assign unused_alpha  = ^{fifo_data_in[W-1 -: 8], shreg[W-1 -: 8]};

  // Pixel slot counter; free-runs across lines because H_ACTIVE is a
  // whole number of words, and restarts whenever the frame goes inactive.
  always_ff @(posedge video_clk or negedge video_rst_n) begin
    if (!video_rst_n) begin
      pix_cnt <= '0;
    end else if (!video_vs_in) begin
      pix_cnt <= '0;
    end else if (video_de_in) begin
      pix_cnt <= (pix_cnt == PCW'(PPW - 1)) ? '0 : pix_cnt + PCW'(1);
    end
  end

  // Stage 1: remember what was decided while the FIFO read is in flight.
  always_ff @(posedge video_clk or negedge video_rst_n) begin
    if (!video_rst_n) begin
      rd_ok_d1 <= 1'b0;
      sel0_d1  <= 1'b0;
      de_d1    <= 1'b0;
      vs_d1    <= 1'b0;
      hs_d1    <= 1'b0;
    end else begin
      rd_ok_d1 <= rd_ok;
      sel0_d1  <= sel0;
      de_d1    <= video_de_in;
      vs_d1    <= video_vs_in;
      hs_d1    <= video_hs_in;
    end
  end

  // Stage 2: pixel output and timing outputs.
  always_ff @(posedge video_clk or negedge video_rst_n) begin
    if (!video_rst_n) begin
      video_data_out <= '0;
      shreg          <= '0;
      video_vs_out   <= 1'b0;
      video_hs_out   <= 1'b0;
      video_de_out   <= 1'b0;
    end else begin
      video_vs_out <= vs_d1;
      video_hs_out <= hs_d1;
      video_de_out <= de_d1;
      if (de_d1) begin
        if (sel0_d1 && rd_ok_d1) begin
          video_data_out <= fifo_data_in[W-9 -: 24];
          shreg          <= fifo_data_in << 32;
        end else if (sel0_d1) begin
          // Starved word: blank every pixel of it.
          video_data_out <= '0;
          shreg          <= '0;
        end else begin
          video_data_out <= shreg[W-9 -: 24];
          shreg          <= shreg << 32;
        end
      end else begin
        video_data_out <= '0;
      end
    end
  end

  always_ff @(posedge video_clk or negedge video_rst_n) begin
    if (!video_rst_n) begin
      underflow <= 1'b0;
    end else if (underflow_set) begin
      underflow <= 1'b1;
    end else if (vs_rise) begin
      underflow <= 1'b0;
    end
  end

  // Line request bookkeeping. line_req counts requests raised this frame;
  // the vs rising edge prefetches line 0.
  always_ff @(posedge video_clk or negedge video_rst_n) begin
    if (!video_rst_n) begin
      line_req <= '0;
    end else if (!video_vs_in) begin
      line_req <= '0;
    end else if (vs_rise) begin
      line_req <= LRW'(1);
    end else if (hs_fall && (line_req < LRW'(V_ACTIVE))) begin
      line_req <= line_req + LRW'(1);
    end
  end

  always_comb begin
    pending_nxt = pending;
    if (req_event && !req_accept) begin
      if (pending != 2'd3) begin
        pending_nxt = pending + 2'd1;
      end
    end else if (req_accept && !req_event) begin
      pending_nxt = pending - 2'd1;
    end
  end

  // VALID is registered from the next pending value so it drops together
  // with the last accept and never offers a phantom request.
  always_ff @(posedge video_clk or negedge video_rst_n) begin
    if (!video_rst_n) begin
      pending              <= 2'd0;
      AXI_FULL_BURST_VALID <= 1'b0;
    end else begin
      pending              <= pending_nxt;
      AXI_FULL_BURST_VALID <= (pending_nxt != 2'd0);
    end
  end

endmodule
